// File: rtl/road_scheduler.sv
// Four-way intersection sequencer: ALL_RED -> GREEN -> YELLOW per road, round-robin with emergency override.
// All outputs registered; green time scales with the selected road's sensor average.
module road_scheduler #(
  parameter int MIN_GREEN   = 4,
  parameter int MAX_GREEN   = 20,
  parameter int YELLOW_TIME = 2,
  parameter int ALLRED_TIME = 1,
  parameter int SCALE_SHIFT = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic [7:0] avg_north,
  input  logic [7:0] avg_east,
  input  logic [7:0] avg_south,
  input  logic [7:0] avg_west,
  input  logic       emerg_req,
  input  logic [1:0] emerg_road,
  output logic [1:0] next_road,
  output logic [1:0] cur_road,
  output logic [3:0] green,
  output logic [3:0] yellow,
  output logic [7:0] remaining,
  output logic       phase_start
);

  typedef enum logic [1:0] {
    S_ALL_RED,
    S_GREEN,
    S_YELLOW
  } state_e;

  state_e     state_q, state_d;
  logic [1:0] next_road_q, next_road_d;
  logic [1:0] cur_road_q, cur_road_d;
  logic [3:0] green_q, green_d;
  logic [3:0] yellow_q, yellow_d;
  logic [7:0] remaining_q, remaining_d;
  logic       phase_start_q, phase_start_d;
  logic       emerg_vld_q, emerg_vld_d;
  logic [1:0] emerg_road_q, emerg_road_d;

  logic [7:0] avg_sel;
  logic [8:0] dur_sum;
  logic [7:0] dur;
  logic       expire;
  logic       emerg_hit;

  // The average of the road about to go green; its sensor has already
  // re-sampled during the all-red interval.
  always_comb begin
    avg_sel = avg_north;
    case (next_road_q)
      2'd0: avg_sel = avg_north;
      2'd1: avg_sel = avg_east;
      2'd2: avg_sel = avg_south;
      2'd3: avg_sel = avg_west;
      default: avg_sel = avg_north;
    endcase
  end

  always_comb begin
    dur_sum = 9'(MIN_GREEN) + {1'b0, (avg_sel >> SCALE_SHIFT)};
    dur     = (dur_sum > 9'(MAX_GREEN)) ? 8'(MAX_GREEN) : dur_sum[7:0];
  end

  assign expire    = tick && (remaining_q == 8'd1);
  assign emerg_hit = emerg_req && (emerg_road != cur_road_q);

  always_comb begin
    state_d       = state_q;
    next_road_d   = next_road_q;
    cur_road_d    = cur_road_q;
    green_d       = green_q;
    yellow_d      = yellow_q;
    remaining_d   = remaining_q;
    phase_start_d = 1'b0;
    emerg_vld_d   = emerg_vld_q;
    emerg_road_d  = emerg_road_q;

    case (state_q)
      S_ALL_RED: begin
        if (expire) begin
          state_d       = S_GREEN;
          cur_road_d    = next_road_q;
          green_d       = 4'b0001 << next_road_q;
          phase_start_d = 1'b1;
          remaining_d   = dur;
        end else if (tick) begin
          remaining_d = remaining_q - 8'd1;
        end
      end

      S_GREEN: begin
        if (emerg_hit || expire) begin
          state_d     = S_YELLOW;
          green_d     = 4'b0000;
          yellow_d    = 4'b0001 << cur_road_q;
          remaining_d = 8'(YELLOW_TIME);
          if (emerg_hit) begin
            emerg_vld_d  = 1'b1;
            emerg_road_d = emerg_road;
          end
        end else if (tick) begin
          remaining_d = remaining_q - 8'd1;
        end
      end

      S_YELLOW: begin
        if (emerg_req) begin
          emerg_vld_d  = 1'b1;
          emerg_road_d = emerg_road;
        end
        if (expire) begin
          state_d     = S_ALL_RED;
          yellow_d    = 4'b0000;
          remaining_d = 8'(ALLRED_TIME);
          emerg_vld_d = 1'b0;
          // A request arriving on the expiry cycle is the latest one and wins.
          if (emerg_req)        next_road_d = emerg_road;
          else if (emerg_vld_q) next_road_d = emerg_road_q;
          else                  next_road_d = cur_road_q + 2'd1;
        end else if (tick) begin
          remaining_d = remaining_q - 8'd1;
        end
      end

      default: begin
        state_d     = S_ALL_RED;
        green_d     = 4'b0000;
        yellow_d    = 4'b0000;
        remaining_d = 8'(ALLRED_TIME);
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_ALL_RED;
      next_road_q   <= 2'd0;
      cur_road_q    <= 2'd0;
      green_q       <= 4'b0000;
      yellow_q      <= 4'b0000;
      remaining_q   <= 8'(ALLRED_TIME);
      phase_start_q <= 1'b0;
      emerg_vld_q   <= 1'b0;
      emerg_road_q  <= 2'd0;
    end else begin
      state_q       <= state_d;
      next_road_q   <= next_road_d;
      cur_road_q    <= cur_road_d;
      green_q       <= green_d;
      yellow_q      <= yellow_d;
      remaining_q   <= remaining_d;
      phase_start_q <= phase_start_d;
      emerg_vld_q   <= emerg_vld_d;
      emerg_road_q  <= emerg_road_d;
    end
  end

  assign next_road   = next_road_q;
  assign cur_road    = cur_road_q;
  assign green       = green_q;
  assign yellow      = yellow_q;
  assign remaining   = remaining_q;
  assign phase_start = phase_start_q;

endmodule

// File: tb/tb_road_scheduler.sv
// Directed bench for road_scheduler: timing, rotation, green clamping, emergency and reset cases.
module tb_road_scheduler;

  logic       clk;
  logic       reset;
  logic       tick;
  logic [7:0] avg_north, avg_east, avg_south, avg_west;
  logic       emerg_req;
  logic [1:0] emerg_road;
  logic [1:0] next_road, cur_road;
  logic [3:0] green, yellow;
  logic [7:0] remaining;
  logic       phase_start;

  int n_pass  = 0;
  int n_total = 0;

  road_scheduler dut (
    .clk         (clk),
    .reset       (reset),
    .tick        (tick),
    .avg_north   (avg_north),
    .avg_east    (avg_east),
    .avg_south   (avg_south),
    .avg_west    (avg_west),
    .emerg_req   (emerg_req),
    .emerg_road  (emerg_road),
    .next_road   (next_road),
    .cur_road    (cur_road),
    .green       (green),
    .yellow      (yellow),
    .remaining   (remaining),
    .phase_start (phase_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One tick pulse spaced four clocks apart; returns at a negedge.
  task automatic ticks(input int n);
    repeat (n) begin
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      idle(3);
    end
  endtask

  task automatic emerg_pulse(input logic [1:0] road);
    emerg_req  = 1'b1;
    emerg_road = road;
    @(negedge clk);
    emerg_req  = 1'b0;
  endtask

  initial begin
    reset = 1'b0; tick = 1'b0; emerg_req = 1'b0; emerg_road = 2'd0;
    avg_north = 8'd20; avg_east = 8'd20; avg_south = 8'd20; avg_west = 8'd20;
    idle(3);
    chk("rst_green",     32'(green), 0);
    chk("rst_yellow",    32'(yellow), 0);
    chk("rst_next_road", 32'(next_road), 0);
    chk("rst_cur_road",  32'(cur_road), 0);
    chk("rst_remaining", 32'(remaining), 1);
    chk("rst_phase",     32'(phase_start), 0);

    reset = 1'b1;
    idle(2);
    chk("no_tick_allred", 32'(remaining), 1);

    // North: 1 tick all-red, then 9-tick green
    tick = 1'b1; @(negedge clk); tick = 1'b0;
    chk("n_green",      32'(green), 4'b0001);
    chk("n_phase",      32'(phase_start), 1);
    chk("n_remaining",  32'(remaining), 9);
    chk("n_cur_road",   32'(cur_road), 0);
    idle(1);
    chk("n_phase_drop", 32'(phase_start), 0);
    idle(2);
    ticks(8);
    chk("n_rem_last",   32'(remaining), 1);
    chk("n_green_last", 32'(green), 4'b0001);
    ticks(1);
    chk("n_yellow",     32'(yellow), 4'b0001);
    chk("n_green_off",  32'(green), 0);
    chk("n_yel_rem",    32'(remaining), 2);
    ticks(2);
    chk("n_yel_done",   32'(yellow), 0);
    chk("n_next_road",  32'(next_road), 1);
    chk("n_allred_rem", 32'(remaining), 1);

    // East green, timer frozen while tick is low
    ticks(1);
    chk("e_green",      32'(green), 4'b0010);
    chk("e_remaining",  32'(remaining), 9);
    idle(50);
    chk("e_frozen",     32'(remaining), 9);
    ticks(9);
    chk("e_yellow",     32'(yellow), 4'b0010);
    ticks(2);
    chk("e_next_road",  32'(next_road), 2);

    // South with avg 0 gets MIN_GREEN
    avg_south = 8'd0;
    ticks(1);
    chk("s_green",      32'(green), 4'b0100);
    chk("s_min_green",  32'(remaining), 4);
    ticks(4);
    chk("s_yellow",     32'(yellow), 4'b0100);
    ticks(2);
    chk("s_next_road",  32'(next_road), 3);
    ticks(1);
    chk("w_green",      32'(green), 4'b1000);
    ticks(9);
    chk("w_yellow",     32'(yellow), 4'b1000);
    ticks(2);
    chk("w_next_road",  32'(next_road), 0);

    // Emergency to south truncates north green at remaining 6
    ticks(1);
    chk("n2_green",     32'(green), 4'b0001);
    ticks(3);
    chk("n2_rem6",      32'(remaining), 6);
    emerg_pulse(2'd2);
    chk("em_yellow",    32'(yellow), 4'b0001);
    chk("em_green_off", 32'(green), 0);
    chk("em_yel_rem",   32'(remaining), 2);
    ticks(2);
    chk("em_next_road", 32'(next_road), 2);
    emerg_pulse(2'd1);
    chk("em_allred_ign", 32'(next_road), 2);
    ticks(1);
    chk("em_s_green",   32'(green), 4'b0100);
    chk("em_s_rem",     32'(remaining), 4);

    // Truncate south toward west, then overwrite to east during yellow
    emerg_pulse(2'd3);
    chk("ov_yellow",    32'(yellow), 4'b0100);
    emerg_pulse(2'd1);
    chk("ov_yel_rem",   32'(remaining), 2);
    avg_east = 8'd255;
    ticks(2);
    chk("ov_next_road", 32'(next_road), 1);
    ticks(1);
    chk("clamp_green",  32'(green), 4'b0010);
    chk("clamp_rem",    32'(remaining), 20);

    // Emergency for the road already green has no effect
    emerg_pulse(2'd1);
    chk("same_green",   32'(green), 4'b0010);
    chk("same_rem",     32'(remaining), 20);
    ticks(19);
    chk("same_last",    32'(green), 4'b0010);
    ticks(1);
    chk("same_yellow",  32'(yellow), 4'b0010);

    // Asynchronous reset mid-yellow
    reset = 1'b0;
    #2;
    chk("ar_green",     32'(green), 0);
    chk("ar_yellow",    32'(yellow), 0);
    chk("ar_next_road", 32'(next_road), 0);
    chk("ar_remaining", 32'(remaining), 1);
    @(negedge clk);
    reset = 1'b1;
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
